// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared state type and digit constants for the microwave cook-timer controller.
package mw_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } mw_state_e;

  localparam logic [3:0]  SEC_T_MAX = 4'd5;
  localparam logic [3:0]  DIGIT_MAX = 4'd9;
  localparam logic [15:0] ZERO_TIME = 16'h0000;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_bcd_down_digit.sv
// One BCD down-counting digit: load beats decrement, wraps 0 -> MAX and signals a borrow.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] q,
  output logic       borrow
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

  assign borrow = en & (q == 4'd0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// MM:SS cook-timer sequencer: keypad entry, run/pause/done control, magnetron and beeper.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | timer 00:00, waiting for the first digit
//   ST_ENTRY | digits being shifted in from the keypad
//   ST_RUN   | magnetron on, time decrements on each 1 Hz tick
//   ST_PAUSE | stopped or door opened, digits frozen
//   ST_DONE  | time expired, beeper on for BEEP_TICKS ticks
module microwave_timer_ctrl
  import mw_timer_pkg::*;
#(
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [3:0] ss_t,
  output logic [3:0] ss_u,
  output logic       mag_on,
  output logic       beep,
  output logic       done,
  output logic       busy
);

  localparam int BW = $clog2(BEEP_TICKS + 1);

  mw_state_e         state, state_nx;
  logic [BW-1:0]     beep_cnt;
  logic              key_ok, time_zero, time_one, start_ok;
  logic              shift, clr_dig, dec, beep_load, beep_dec;
  logic              load_dig;
  logic              brw_ss_u, brw_ss_t, brw_mm_u, unused_brw_mm_t;

  assign key_ok    = key_valid && is_bcd(key_digit);
  assign time_zero = ({mm_t, mm_u, ss_t, ss_u} == ZERO_TIME);
  assign time_one  = ({mm_t, mm_u, ss_t, ss_u} == 16'h0001);
  assign start_ok  = door_closed && !time_zero && (ss_t <= SEC_T_MAX);
  assign load_dig  = shift | clr_dig;

  always_comb begin
    state_nx  = state;
    shift     = 1'b0;
    clr_dig   = 1'b0;
    dec       = 1'b0;
    beep_load = 1'b0;
    beep_dec  = 1'b0;
    if (clear) begin
      clr_dig  = 1'b1;
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_ok) begin
            shift    = 1'b1;
            state_nx = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (stop) begin
            clr_dig  = 1'b1;
            state_nx = ST_IDLE;
          end else if (start && start_ok) begin
            state_nx = ST_RUN;
          end else if (key_ok) begin
            shift = 1'b1;
          end
        end
        ST_RUN: begin
          if (stop || !door_closed) begin
            state_nx = ST_PAUSE;
          end else if (tick_1hz && !time_zero) begin
            dec = 1'b1;
            // 00:01 decrements straight into DONE on this same edge
            if (time_one) begin
              state_nx  = ST_DONE;
              beep_load = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            clr_dig  = 1'b1;
            state_nx = ST_IDLE;
          end else if (start && door_closed) begin
            state_nx = ST_RUN;
          end
        end
        ST_DONE: begin
          if (stop || key_ok) begin
            state_nx = ST_IDLE;
          end else if (tick_1hz) begin
            if (beep_cnt <= BW'(1)) state_nx = ST_IDLE;
            else                    beep_dec = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      beep_cnt <= '0;
      mag_on   <= 1'b0;
      beep     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nx;
      if (beep_load)                 beep_cnt <= BW'(BEEP_TICKS);
      else if (beep_dec)             beep_cnt <= beep_cnt - BW'(1);
      else if (state_nx != ST_DONE)  beep_cnt <= '0;
      mag_on <= (state_nx == ST_RUN);
      beep   <= (state_nx == ST_DONE);
      done   <= (state_nx == ST_DONE);
      busy   <= (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
    end
  end

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_ss_u (
    .clk(clk), .clrn(clrn), .load(load_dig),
    .load_val(clr_dig ? 4'd0 : key_digit),
    .en(dec), .q(ss_u), .borrow(brw_ss_u)
  );

  bcd_down_digit #(.MAX(SEC_T_MAX)) u_ss_t (
    .clk(clk), .clrn(clrn), .load(load_dig),
    .load_val(clr_dig ? 4'd0 : ss_u),
    .en(brw_ss_u), .q(ss_t), .borrow(brw_ss_t)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_mm_u (
    .clk(clk), .clrn(clrn), .load(load_dig),
    .load_val(clr_dig ? 4'd0 : ss_t),
    .en(brw_ss_t), .q(mm_u), .borrow(brw_mm_u)
  );

  // mm_t borrow never fires: RUN stops decrementing at 00:00
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_mm_t (
    .clk(clk), .clrn(clrn), .load(load_dig),
    .load_val(clr_dig ? 4'd0 : mm_u),
    .en(brw_mm_u), .q(mm_t), .borrow(unused_brw_mm_t)
  );

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed and randomized checks of microwave_timer_ctrl against a seconds-based reference model.
module tb_microwave_timer_ctrl;

  localparam int BT = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk, clrn, tick_1hz, key_valid, start, stop, clear, door_closed;
  logic [3:0] key_digit, mm_t, mm_u, ss_t, ss_u;
  logic       mag_on, beep, done, busy;

  int checks = 0;
  int failures = 0;
  int mv, mst, mbl;

  microwave_timer_ctrl #(.BEEP_TICKS(BT)) dut (
    .clk(clk), .clrn(clrn), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .stop(stop), .clear(clear),
    .door_closed(door_closed), .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
    .mag_on(mag_on), .beep(beep), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // time as plain seconds: MMSS -> seconds - 1 -> MMSS
  function automatic int dec_time(input int v);
    int s;
    s = (v / 100) * 60 + (v % 100) - 1;
    return (s / 60) * 100 + (s % 60);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_digits"}, 32'({mm_t, mm_u, ss_t, ss_u}), 32'(to_bcd(mv)));
    chk({tag, "_mag"},  32'(mag_on), 32'(mst == M_RUN));
    chk({tag, "_beep"}, 32'(beep),   32'(mst == M_DONE));
    chk({tag, "_done"}, 32'(done),   32'(mst == M_DONE));
    chk({tag, "_busy"}, 32'(busy),   32'(mst == M_RUN || mst == M_PAUSE));
  endtask

  task automatic model_reset();
    mv = 0; mst = M_IDLE; mbl = 0;
  endtask

  task automatic model_step();
    logic kok;
    kok = key_valid && (key_digit <= 4'd9);
    if (clear) begin
      mv = 0; mst = M_IDLE;
    end else begin
      case (mst)
        M_IDLE:  if (kok) begin mv = int'(key_digit); mst = M_ENTRY; end
        M_ENTRY: begin
          if (stop) begin mv = 0; mst = M_IDLE; end
          else if (start && door_closed && mv != 0 && ((mv / 10) % 10) <= 5) mst = M_RUN;
          else if (kok) mv = (mv * 10 + int'(key_digit)) % 10000;
        end
        M_RUN: begin
          if (stop || !door_closed) mst = M_PAUSE;
          else if (tick_1hz && mv != 0) begin
            mv = dec_time(mv);
            if (mv == 0) begin mst = M_DONE; mbl = BT; end
          end
        end
        M_PAUSE: begin
          if (stop) begin mv = 0; mst = M_IDLE; end
          else if (start && door_closed) mst = M_RUN;
        end
        default: begin
          if (stop || kok) mst = M_IDLE;
          else if (tick_1hz) begin
            mbl--;
            if (mbl == 0) mst = M_IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    model_step();
    tick_1hz = 1'b0; key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    check_all(tag);
  endtask

  task automatic press(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    cyc("key");
  endtask

  task automatic tick(input string tag);
    tick_1hz = 1'b1;
    cyc(tag);
    cyc("gap");
  endtask

  initial begin
    clrn = 1'b0; tick_1hz = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_digits_const", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0);
    @(negedge clk) clrn = 1'b1;
    cyc("idle");

    // 01:30 cook to completion, then beeper for BT ticks
    press(1); press(3); press(0);
    start = 1'b1;
    cyc("start130");
    chk("start130_digits", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0130);
    chk("start130_mag", 32'(mag_on), 32'd1);
    for (int k = 0; k < 90; k++) begin
      tick_1hz = 1'b1;
      cyc("run130");
      if (k == 89) begin
        chk("end_digits", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0);
        chk("end_done", 32'(done), 32'd1);
        chk("end_mag", 32'(mag_on), 32'd0);
      end
      cyc("gap");
    end
    for (int k = 0; k < BT; k++) begin
      chk("beep_on", 32'(beep), 32'd1);
      tick("beep_tick");
    end
    chk("beep_off", 32'(beep), 32'd0);
    chk("beep_idle_done", 32'(done), 32'd0);

    // full borrow chain and seconds-only decrement
    press(1); press(0); press(0); press(0);
    start = 1'b1; cyc("start1000");
    tick("t1000");
    chk("borrow_chain", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0959);
    clear = 1'b1; cyc("clr");
    press(1); press(0);
    start = 1'b1; cyc("start0010");
    tick("t0010");
    chk("ss_borrow", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0009);
    clear = 1'b1; cyc("clr");

    // door opens together with a tick: tick dropped, PAUSE
    press(2); press(0); press(0);
    start = 1'b1; cyc("start0200");
    door_closed = 1'b0; tick_1hz = 1'b1; cyc("door_open");
    chk("pause_digits", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0200);
    chk("pause_mag", 32'(mag_on), 32'd0);
    chk("pause_busy", 32'(busy), 32'd1);
    door_closed = 1'b1; start = 1'b1; cyc("resume");
    chk("resume_mag", 32'(mag_on), 32'd1);
    tick("t_resume");
    chk("resume_tick", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0159);
    stop = 1'b1; cyc("stop_pause");
    stop = 1'b1; cyc("stop_idle");

    // rejected starts and five-digit entry
    press(0); press(0); press(7); press(5);
    start = 1'b1; cyc("start_bad_sst");
    chk("bad_sst_mag", 32'(mag_on), 32'd0);
    chk("bad_sst_digits", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0075);
    clear = 1'b1; cyc("clr");
    press(0); press(0);
    start = 1'b1; cyc("start_zero");
    chk("zero_start_mag", 32'(mag_on), 32'd0);
    clear = 1'b1; cyc("clr");
    press(1); press(2); press(3); press(4); press(5);
    chk("five_keys", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h2345);
    clear = 1'b1; cyc("clr");

    // key in DONE aborts the beep without entering the digit
    press(2); start = 1'b1; cyc("start0002");
    tick("t2"); tick("t1");
    chk("done_reached", 32'(done), 32'd1);
    press(4);
    chk("done_key_done", 32'(done), 32'd0);
    chk("done_key_digits", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0);

    // clear mid-RUN at 05:17
    press(5); press(1); press(7); start = 1'b1; cyc("start0517");
    clear = 1'b1; cyc("clr_run");
    chk("clr_run_mag", 32'(mag_on), 32'd0);
    chk("clr_run_digits", 32'({mm_t, mm_u, ss_t, ss_u}), 32'h0);

    // asynchronous reset mid-RUN, checked between clock edges
    press(3); start = 1'b1; cyc("start0003");
    #2 clrn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_mag", 32'(mag_on), 32'd0);
    @(negedge clk);
    @(negedge clk) clrn = 1'b1;
    cyc("post_rst");

    // randomized mix of commands, ticks and door activity
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 99) < 3) door_closed = ~door_closed;
      if (r < 2) clear = 1'b1;
      else if (r < 6) stop = 1'b1;
      else if (door_closed && r < 16) start = 1'b1;
      else if (door_closed && r < 40) begin
        key_valid = 1'b1;
        key_digit = 4'($urandom_range(0, 15));
      end
      else if (door_closed && r < 75) tick_1hz = 1'b1;
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
